onchip_mem_arbiter: RTL and testbench
=====================================

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 The block SHALL have parameters: NUM_REQ, default 4, number of requesters (2..10); ADDR_W, default 16, word-address width; DATA_W, default 32, data width; DEPTH, default 64000, memory words; CLEAR_ON_RESET, default 1, zero-fill memory after reset.
REQ-002 The block SHALL have ports:
clk  in  1  single clock, all logic rising-edge.
reset_n  in  1  asynchronous, active-low reset.
req_address  in  NUM_REQ*ADDR_W  per-requester word address (slice i = requester i).
req_byteenable  in  NUM_REQ*4  per-requester byte enables.
req_read  in  NUM_REQ  per-requester read request.
req_write  in  NUM_REQ  per-requester write request.
req_writedata  in  NUM_REQ*DATA_W  per-requester write data.
req_waitrequest  out  NUM_REQ  high = request not accepted this cycle.
req_readdata  out  DATA_W  shared read data, qualified by req_readdatavalid.
req_readdatavalid  out  NUM_REQ  one-hot read-data strobe.
clear_start  in  1  pulse: start memory zero-fill.
clear_busy  out  1  zero-fill in progress.
mem_address  out  ADDR_W  to memory.
mem_byteenable  out  4  to memory.
mem_chipselect  out  1  to memory.
mem_write  out  1  to memory.
mem_writedata  out  DATA_W  to memory.
mem_clken  out  1  to memory, constant 1.
mem_readdata  in  DATA_W  memory q; valid one cycle after address is presented.

Function
REQ-003 The block SHALL implement states CLEAR and ARB; CLEAR->ARB when the clear counter reaches DEPTH-1 and that write is issued; ARB->CLEAR on clear_start=1 in ARB.
REQ-004 In CLEAR the block SHALL drive mem_chipselect=1, mem_write=1, mem_byteenable=4'hF, mem_writedata=0, mem_address=clear counter, incrementing by 1 per cycle from 0; all req_waitrequest=1; clear_busy=1.
REQ-005 clear_start asserted while in CLEAR SHALL be ignored (counter not restarted).
REQ-006 In ARB a requester i SHALL be eligible when req_read[i] or req_write[i] is 1; exactly one eligible requester SHALL be granted per cycle, combinationally, by round-robin.
REQ-007 Round-robin: search starts at index (last_grant+1) mod NUM_REQ, ascending with wrap; last_grant updates only on a grant; last_grant after reset = NUM_REQ-1 (requester 0 has first priority).
REQ-008 Granted requester SHALL see req_waitrequest[i]=0 that cycle; all others req_waitrequest=1; with no eligible requester, all req_waitrequest=1 and mem_chipselect=0.
REQ-009 On grant the block SHALL drive mem_chipselect=1, mem_address/byteenable/writedata from the granted slices, mem_write=req_write[i].
REQ-010 If req_read[i] and req_write[i] are both 1, the request SHALL be treated as a write and produce no readdatavalid.
REQ-011 A granted read in cycle N SHALL produce req_readdatavalid[i]=1 for exactly cycle N+1 with req_readdata=mem_readdata; fixed latency 1, throughput one transfer per cycle.
REQ-012 Back-to-back reads by different requesters SHALL yield consecutive, correctly one-hot readdatavalid pulses with no gaps.
REQ-013 A read granted in the last ARB cycle before entering CLEAR SHALL still deliver its readdatavalid in the next cycle.
REQ-014 req_readdata SHALL be mem_readdata unregistered; its value outside readdatavalid is don't-care.

Reset
REQ-015 While reset_n=0: state = CLEAR if CLEAR_ON_RESET=1 else ARB; clear counter=0; last_grant=NUM_REQ-1; readdatavalid pipeline=0; all req_waitrequest=1; req_readdatavalid=0; mem_chipselect=0 and mem_write=0 during reset.
REQ-016 Reset assertion mid-CLEAR or mid-transfer SHALL abandon the operation; a pending readdatavalid SHALL NOT be issued; after release, zero-fill restarts from address 0.

Verification
REQ-017 Reset release, CLEAR_ON_RESET=1, DEPTH=16 -> 16 writes of 0 to addresses 0..15 on consecutive cycles, clear_busy=1 for 16 cycles, then ARB.
REQ-018 Requesters 0,1,2 hold read continuously at addresses 5,6,7 -> grants 0,1,2,0,1,...; readdatavalid one-hot 1 cycle after each grant with data from mem[5], mem[6], mem[7].
REQ-019 Requester 3 writes 32'hDEADBEEF, byteenable 4'b0011, address 9; next requester 2 reads 9 -> readdata 32'h0000BEEF with memory pre-cleared.
REQ-020 Requester 1 asserts read and write together at address 3 -> write performed, no readdatavalid for requester 1.
REQ-021 clear_start pulse in ARB while requester 0 reads -> pending readdatavalid delivered next cycle, then zero-fill, waitrequest=1 throughout, clear_start repeated mid-clear ignored.
REQ-022 reset_n pulled low mid-CLEAR at counter 7 -> outputs reset immediately; after release fill restarts at address 0.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one single-port on-chip memory.
// It also runs a zero-fill sequencer that clears the memory after reset or on request.
module onchip_mem_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 64000,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*4-1:0]        req_byteenable,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]          req_waitrequest,
    output logic [DATA_W-1:0]           req_readdata,
    output logic [NUM_REQ-1:0]          req_readdatavalid,
    input  logic                        clear_start,
    output logic                        clear_busy,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [3:0]                  mem_byteenable,
    output logic                        mem_chipselect,
    output logic                        mem_write,
    output logic [DATA_W-1:0]           mem_writedata,
    output logic                        mem_clken,
    input  logic [DATA_W-1:0]           mem_readdata
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [GW-1:0]     LAST_REQ  = GW'(NUM_REQ - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_nxt;
    logic [GW-1:0]       r_last_grant;
    logic [GW-1:0]       w_grant_idx;
    logic                w_grant_vld;
    logic [NUM_REQ-1:0]  w_elig;
    logic [NUM_REQ-1:0]  w_grant_oh;
    logic [NUM_REQ-1:0]  r_rdv;
    logic [NUM_REQ-1:0]  w_rdv_nxt;
    logic [NUM_REQ-1:0]  w_wait;
    logic                w_cs;
    logic                w_we;

    assign w_elig     = req_read | req_write;
    assign w_grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx;

    // Round-robin search: the first eligible index after last_grant wins.
    always_comb begin
        logic [GW-1:0] cand;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        cand        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand        = GW'((int'(r_last_grant) + k) % NUM_REQ);
            w_grant_idx = w_elig[cand] ? cand : w_grant_idx;
            w_grant_vld = w_grant_vld | w_elig[cand];
        end
    end

    // Next-state and memory-port steering for the CLEAR / ARB machine.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_rdv_nxt      = '0;
        w_wait         = '1;
        w_cs           = 1'b0;
        w_we           = 1'b0;
        clear_busy     = 1'b0;
        mem_address    = '0;
        mem_byteenable = 4'h0;
        mem_writedata  = '0;
        case (r_state)
            ST_CLEAR: begin
                clear_busy     = 1'b1;
                w_cs           = 1'b1;
                w_we           = 1'b1;
                mem_byteenable = 4'hF;
                mem_address    = r_clr_cnt;
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_nxt   = ST_ARB;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                end
            end
            ST_ARB: begin
                if (w_grant_vld) begin
                    w_wait         = ~w_grant_oh;
                    w_cs           = 1'b1;
                    w_we           = req_write[w_grant_idx];
                    mem_address    = req_address[w_grant_idx*ADDR_W +: ADDR_W];
                    mem_byteenable = req_byteenable[w_grant_idx*4 +: 4];
                    mem_writedata  = req_writedata[w_grant_idx*DATA_W +: DATA_W];
                    // Read+write together counts as a write: no read strobe.
                    w_rdv_nxt      = req_write[w_grant_idx] ? '0 : w_grant_oh;
                end else begin
                    w_wait = '1;
                end
                if (clear_start) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_state_nxt   = ST_ARB;
                end
            end
            default: begin
                w_state_nxt   = RST_STATE;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // State, clear counter, grant history and read-valid pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= RST_STATE;
            r_clr_cnt    <= '0;
            r_last_grant <= LAST_REQ;
            r_rdv        <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_rdv     <= w_rdv_nxt;
            if ((r_state == ST_ARB) && w_grant_vld) begin
                r_last_grant <= w_grant_idx;
            end else begin
                r_last_grant <= r_last_grant;
            end
        end
    end

    // Memory strobes are held inactive for as long as reset is asserted.
    assign req_waitrequest   = reset_n ? w_wait : '1;
    assign mem_chipselect    = reset_n & w_cs;
    assign mem_write         = reset_n & w_we;
    assign mem_clken         = 1'b1;
    assign req_readdatavalid = r_rdv;
    assign req_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a synchronous memory with byte enables, plus a reference model
// that tracks fill progress, round-robin order and memory contents.
module tb_onchip_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int DP = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR*AW-1:0] req_address;
    logic [NR*4-1:0]  req_byteenable;
    logic [NR-1:0]    req_read;
    logic [NR-1:0]    req_write;
    logic [NR*DW-1:0] req_writedata;
    logic [NR-1:0]    req_waitrequest;
    logic [DW-1:0]    req_readdata;
    logic [NR-1:0]    req_readdatavalid;
    logic             clear_start;
    logic             clear_busy;
    logic [AW-1:0]    mem_address;
    logic [3:0]       mem_byteenable;
    logic             mem_chipselect;
    logic             mem_write;
    logic [DW-1:0]    mem_writedata;
    logic             mem_clken;
    logic [DW-1:0]    mem_readdata;

    onchip_mem_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_address(req_address), .req_byteenable(req_byteenable),
        .req_read(req_read), .req_write(req_write), .req_writedata(req_writedata),
        .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT: registered read port, byte-enabled writes.
    logic [DW-1:0] tb_mem [0:DP-1];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) tb_mem[mem_address % DP][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_readdata <= tb_mem[mem_address % DP];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [0:DP-1];
    bit            m_clear;
    int            m_cnt;
    int            m_last;
    logic [NR-1:0] exp_rdv;
    logic [DW-1:0] exp_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr, input int addr,
                           input logic [3:0] be, input logic [DW-1:0] wd);
        req_read[i]               = rd;
        req_write[i]              = wr;
        req_address[i*AW +: AW]   = AW'(addr);
        req_byteenable[i*4 +: 4]  = be;
        req_writedata[i*DW +: DW] = wd;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    endtask

    // One clock cycle: check outputs against the model with the current inputs, then advance the model.
    task automatic tick();
        int            g;
        int            a;
        logic [NR-1:0] nrdv;
        logic [DW-1:0] nrdata;
        logic [DW-1:0] wd;
        logic [3:0]    be;
        #1;
        nrdv   = '0;
        nrdata = '0;
        if (!reset_n) begin
            m_clear = 1'b1;
            m_cnt   = 0;
            m_last  = NR - 1;
            chk("rst_wait", req_waitrequest, 64'hF);
            chk("rst_cs",   mem_chipselect,  64'h0);
            chk("rst_we",   mem_write,       64'h0);
            chk("rst_rdv",  req_readdatavalid, 64'h0);
        end else begin
            chk("rdv", req_readdatavalid, exp_rdv);
            if (exp_rdv != '0) chk("rdata", req_readdata, exp_rdata);
            if (m_clear) begin
                chk("clr_busy", clear_busy,      64'h1);
                chk("clr_wait", req_waitrequest, 64'hF);
                chk("clr_cs",   mem_chipselect,  64'h1);
                chk("clr_we",   mem_write,       64'h1);
                chk("clr_be",   mem_byteenable,  64'hF);
                chk("clr_wd",   mem_writedata,   64'h0);
                chk("clr_addr", mem_address,     64'(m_cnt));
                ref_mem[m_cnt] = '0;
                if (m_cnt == DP - 1) begin
                    m_clear = 1'b0;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                g = -1;
                for (int k = 1; k <= NR; k++) begin
                    int c;
                    c = (m_last + k) % NR;
                    if (g < 0 && (req_read[c] || req_write[c])) g = c;
                end
                chk("arb_busy", clear_busy, 64'h0);
                if (g < 0) begin
                    chk("idle_wait", req_waitrequest, 64'hF);
                    chk("idle_cs",   mem_chipselect,  64'h0);
                end else begin
                    a  = int'(req_address[g*AW +: AW]);
                    be = req_byteenable[g*4 +: 4];
                    wd = req_writedata[g*DW +: DW];
                    chk("gnt_wait", req_waitrequest, 64'((~(4'b0001 << g)) & 4'hF));
                    chk("gnt_cs",   mem_chipselect,  64'h1);
                    chk("gnt_we",   mem_write,       64'(req_write[g]));
                    chk("gnt_addr", mem_address,     64'(a));
                    chk("gnt_be",   mem_byteenable,  64'(be));
                    if (req_write[g]) begin
                        chk("gnt_wd", mem_writedata, 64'(wd));
                        for (int b = 0; b < 4; b++)
                            if (be[b]) ref_mem[a % DP][8*b +: 8] = wd[8*b +: 8];
                    end else begin
                        nrdv   = NR'(1) << g;
                        nrdata = ref_mem[a % DP];
                    end
                    m_last = g;
                end
                if (clear_start) begin
                    m_clear = 1'b1;
                    m_cnt   = 0;
                end
            end
        end
        exp_rdv   = nrdv;
        exp_rdata = nrdata;
        @(negedge clk);
    endtask

    initial begin
        int guard;
        reset_n     = 1'b0;
        clear_start = 1'b0;
        req_address = '0; req_byteenable = '0; req_read = '0; req_write = '0; req_writedata = '0;
        for (int i = 0; i < DP; i++) ref_mem[i] = '0;
        m_clear = 1'b1; m_cnt = 0; m_last = NR - 1; exp_rdv = '0; exp_rdata = '0;
        @(negedge clk);
        repeat (3) tick();

        // Fill after reset release: 16 zero writes, then arbitration
        reset_n = 1'b1;
        repeat (DP) tick();
        tick();

        // Three requesters hold reads at addresses 5,6,7
        set_req(0, 1'b1, 1'b0, 5, 4'hF, 32'h0);
        set_req(1, 1'b1, 1'b0, 6, 4'hF, 32'h0);
        set_req(2, 1'b1, 1'b0, 7, 4'hF, 32'h0);
        repeat (9) tick();
        idle_all();
        tick();

        // Partial write then read-back by another requester
        set_req(3, 1'b0, 1'b1, 9, 4'b0011, 32'hDEADBEEF);
        tick();
        idle_all();
        set_req(2, 1'b1, 1'b0, 9, 4'hF, 32'h0);
        tick();
        chk("req019_rdv",  req_readdatavalid, 64'h4);
        chk("req019_data", req_readdata,      64'h0000BEEF);
        idle_all();
        tick();

        // Read and write together behave as a write
        set_req(1, 1'b1, 1'b1, 3, 4'hF, 32'h12345678);
        tick();
        idle_all();
        tick();
        set_req(0, 1'b1, 1'b0, 3, 4'hF, 32'h0);
        tick();
        idle_all();
        tick();

        // Randomised traffic with occasional clear requests
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NR; i++)
                set_req(i, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                        int'($urandom_range(0, DP - 1)), 4'($urandom_range(0, 15)), $urandom);
            clear_start = ($urandom_range(0, 59) == 0);
            tick();
        end
        clear_start = 1'b0;
        idle_all();
        guard = 0;
        while (m_clear && guard < 40) begin tick(); guard++; end
        tick();

        // Clear request during a read: pending strobe still delivered, repeat pulse ignored
        set_req(0, 1'b1, 1'b0, 4, 4'hF, 32'h0);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (5) tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (14) tick();
        idle_all();
        tick();

        // Reset mid-fill at counter 7, then fill restarts at 0
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        guard = 0;
        while (m_cnt != 7 && guard < 40) begin tick(); guard++; end
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (DP + 2) tick();

        // Reset right after a read grant drops the pending strobe
        set_req(1, 1'b1, 1'b0, 2, 4'hF, 32'h0);
        tick();
        idle_all();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (DP + 2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
